vmu_mem_responder: RTL and testbench
====================================

// Module: vmu_mem_responder
// PURPOSE
//  Responder end of the vector memory request/response interface driven by vmu.
//  Accepts vector_mem_req beats (load/store, address, ticket, data) and buffers them in a request FIFO.
//  Executes them one at a time on a single-outstanding 32-bit data bus.
//  Returns ticketed vector_mem_resp beats for loads only; stores complete silently.
// PARAMETERS
//  REQ_DATA_WIDTH  32  data width of request/response and bus (must be 32)
//  ADDR_WIDTH      32  request/bus address width
//  VECTOR_LANES    8   sets ticket width TW = $clog2(VECTOR_LANES)
//  FIFO_DEPTH      4   request FIFO entries, power of 2, >=2
//  TIMEOUT         255 bus cycles without ack before forced error completion, >=1
// PORTS
//  clk               in   1    clock, rising edge
//  rst_n             in   1    asynchronous active-low reset
//  mem_req_valid_i   in   1    request beat valid
//  mem_req_i         in   vector_mem_req   {address, microop, ticket, data}
//  cache_ready_o     out  1    request accepted when valid & ready
//  mem_resp_valid_o  out  1    load response valid, single-cycle pulse, no backpressure
//  mem_resp_o        out  vector_mem_resp  {ticket, data}
//  bus_addr_o        out  ADDR_WIDTH   word-aligned access address ({addr[31:2],2'b00})
//  bus_wdata_o       out  32   store data
//  bus_ben_o         out  4    byte enables, always 4'b1111
//  bus_re_o          out  1    read strobe, one-cycle pulse
//  bus_we_o          out  1    write strobe, one-cycle pulse
//  bus_rdata_i       in   32   read data, valid with ack
//  bus_ack_i         in   1    access complete
//  bus_err_i         in   1    access failed (treated as completion)
//  err_o             out  1    sticky: any bus error or timeout since reset
//  idle_o            out  1    FIFO empty and FSM in IDLE
// BEHAVIOUR
//  Reset: FIFO empty, FSM=IDLE, cache_ready_o=1, all strobes/resp_valid/err_o=0, data/addr/ticket regs 0, idle_o=1.
//  Accept: push when mem_req_valid_i & cache_ready_o; cache_ready_o = ~full (registered count, no bypass).
//   Pop in the same cycle as a push at full does not raise ready that cycle.
//  Decode: microop==opcode_vstore_c -> store; any other microop -> load.
//  FSM IDLE: FIFO non-empty -> pop head, latch addr/data/ticket/kind, goto REQ.
//  REQ: assert bus_re_o (load) or bus_we_o (store) for exactly this cycle; clear timer; goto WAIT.
//   Address/wdata held stable from REQ until completion.
//  WAIT: timer++ each cycle; ack or err sampled same cycle as REQ+1 or later -> goto RESP.
//   timer==TIMEOUT-1 without ack/err -> error completion, goto RESP.
//   ack and err together -> treated as err.
//  RESP: load -> mem_resp_valid_o=1 this cycle, ticket=latched ticket, data=bus_rdata_i (ack) or 0 (err/timeout).
//   Store -> no response. Either -> err_o set on err/timeout; goto IDLE.
//  Latency: accept at cycle N into empty idle block -> pop N+1, REQ N+2,
//   ack at N+3 -> mem_resp_valid_o at N+4. Back-to-back throughput: one access per 4 cycles minimum.
//  Ordering: strictly in-order; responses in request order; tickets echoed unmodified (TW bits).
//  Acks/errs outside WAIT are ignored. FIFO pointers wrap modulo FIFO_DEPTH; count is $clog2(FIFO_DEPTH)+1 bits.
//  Reset mid-access: everything returns to reset values immediately; in-flight access is dropped, no response.
// TESTING
//  Single load addr 0x100 ticket 3, bus acks 2 cycles after re with 0xDEADBEEF -> one resp {ticket 3, 0xDEADBEEF}.
//  Store addr 0x204 data 0x12345678 -> one we pulse, addr 0x204, wdata 0x12345678, ben 4'hF; no mem_resp_valid_o.
//  Push 5 loads with no ack (FIFO_DEPTH=4) -> ready drops after 4th queued + 1 in flight; ack all -> tickets in order.
//  Load with no ack, TIMEOUT=8 -> resp data 0 after timeout, err_o=1 and sticky; next load completes normally.
//  Load with bus_err_i -> resp data 0, err_o=1; mixed load/store/load stream -> only 2 responses, correct order.
//  Assert rst_n low during WAIT -> strobes/resp low, FIFO empty, ready=1, idle_o=1; late ack is ignored.

Source files
------------

// File: rtl/vmu_mem_responder_if.sv
// Vector memory request/response channel plus the single-outstanding 32-bit data bus,
// grouped so the responder and its driver see matching directions.
interface vmu_mem_responder_if #(
  parameter int REQ_DATA_WIDTH = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int VECTOR_LANES   = 8,
  parameter int MICROOP_WIDTH  = 4
);
  localparam int TW = $clog2(VECTOR_LANES);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]     address;
    logic [MICROOP_WIDTH-1:0]  microop;
    logic [TW-1:0]             ticket;
    logic [REQ_DATA_WIDTH-1:0] data;
  } vector_mem_req;

  typedef struct packed {
    logic [TW-1:0]             ticket;
    logic [REQ_DATA_WIDTH-1:0] data;
  } vector_mem_resp;

  logic                      mem_req_valid_i;
  vector_mem_req             mem_req_i;
  logic                      cache_ready_o;
  logic                      mem_resp_valid_o;
  vector_mem_resp            mem_resp_o;

  logic [ADDR_WIDTH-1:0]     bus_addr_o;
  logic [REQ_DATA_WIDTH-1:0] bus_wdata_o;
  logic [3:0]                bus_ben_o;
  logic                      bus_re_o;
  logic                      bus_we_o;
  logic [REQ_DATA_WIDTH-1:0] bus_rdata_i;
  logic                      bus_ack_i;
  logic                      bus_err_i;

  modport slave (
    input  mem_req_valid_i, mem_req_i, bus_rdata_i, bus_ack_i, bus_err_i,
    output cache_ready_o, mem_resp_valid_o, mem_resp_o,
    output bus_addr_o, bus_wdata_o, bus_ben_o, bus_re_o, bus_we_o
  );

  modport master (
    output mem_req_valid_i, mem_req_i, bus_rdata_i, bus_ack_i, bus_err_i,
    input  cache_ready_o, mem_resp_valid_o, mem_resp_o,
    input  bus_addr_o, bus_wdata_o, bus_ben_o, bus_re_o, bus_we_o
  );
endinterface

// File: rtl/vmu_mem_responder.sv
// Responder for vmu vector memory beats: queues requests, runs them one at a time on the
// data bus, and returns ticketed responses for loads only.
module vmu_mem_responder #(
  parameter int REQ_DATA_WIDTH = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int VECTOR_LANES   = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT        = 255,
  parameter int MICROOP_WIDTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  vmu_mem_responder_if.slave   bus,
  output logic                 err_o,
  output logic                 idle_o
);
  localparam int TW  = $clog2(VECTOR_LANES);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;
  localparam int TMW = $clog2(TIMEOUT + 1);
  localparam logic [MICROOP_WIDTH-1:0] OPCODE_VSTORE_C = MICROOP_WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t                    r_state;
  state_t                    w_nextState;

  logic [ADDR_WIDTH-3:0]     r_fifoAddr   [FIFO_DEPTH];
  logic [REQ_DATA_WIDTH-1:0] r_fifoData   [FIFO_DEPTH];
  logic [TW-1:0]             r_fifoTicket [FIFO_DEPTH];
  logic                      r_fifoStore  [FIFO_DEPTH];
  logic [PW-1:0]             r_wrPtr;
  logic [PW-1:0]             r_rdPtr;
  logic [CW-1:0]             r_count;

  logic [ADDR_WIDTH-3:0]     r_addr;
  logic [REQ_DATA_WIDTH-1:0] r_wdata;
  logic [TW-1:0]             r_ticket;
  logic                      r_isStore;
  logic [TMW-1:0]            r_timer;
  logic [REQ_DATA_WIDTH-1:0] r_respData;
  logic                      r_err;

  logic w_full, w_empty, w_push, w_pop;
  logic w_timeout, w_failed, w_done;
  logic w_unusedAddrLsbs;

  assign w_full  = (r_count == CW'(FIFO_DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = bus.mem_req_valid_i & ~w_full;
  assign w_pop   = (r_state == S_IDLE) & ~w_empty;

  // Only word accesses exist on the bus, so the byte offset is dropped at enqueue.
  assign w_unusedAddrLsbs = ^bus.mem_req_i.address[1:0];

  assign w_timeout = (r_timer == TMW'(TIMEOUT - 1)) & ~bus.bus_ack_i & ~bus.bus_err_i;
  assign w_failed  = bus.bus_err_i | w_timeout;
  assign w_done    = bus.bus_ack_i | w_failed;

  assign bus.cache_ready_o = ~w_full;
  assign bus.bus_addr_o    = {r_addr, 2'b00};
  assign bus.bus_wdata_o   = r_wdata;
  assign bus.bus_ben_o     = 4'b1111;
  assign bus.mem_resp_o    = {r_ticket, r_respData};
  assign err_o             = r_err;
  assign idle_o            = w_empty & (r_state == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifoAddr[i]   <= '0;
        r_fifoData[i]   <= '0;
        r_fifoTicket[i] <= '0;
        r_fifoStore[i]  <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_fifoAddr[r_wrPtr]   <= bus.mem_req_i.address[ADDR_WIDTH-1:2];
        r_fifoData[r_wrPtr]   <= bus.mem_req_i.data;
        r_fifoTicket[r_wrPtr] <= bus.mem_req_i.ticket;
        r_fifoStore[r_wrPtr]  <= (bus.mem_req_i.microop == OPCODE_VSTORE_C);
        r_wrPtr               <= r_wrPtr + PW'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Access context is captured at pop and held untouched until the response cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr     <= '0;
      r_wdata    <= '0;
      r_ticket   <= '0;
      r_isStore  <= 1'b0;
      r_timer    <= '0;
      r_respData <= '0;
      r_err      <= 1'b0;
    end else begin
      if (w_pop) begin
        r_addr    <= r_fifoAddr[r_rdPtr];
        r_wdata   <= r_fifoData[r_rdPtr];
        r_ticket  <= r_fifoTicket[r_rdPtr];
        r_isStore <= r_fifoStore[r_rdPtr];
      end
      if (r_state == S_REQ) begin
        r_timer <= '0;
      end
      if (r_state == S_WAIT) begin
        r_timer <= r_timer + TMW'(1);
        if (w_done) begin
          r_respData <= w_failed ? '0 : bus.bus_rdata_i;
          if (w_failed) begin
            r_err <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    w_nextState          = r_state;
    bus.bus_re_o         = 1'b0;
    bus.bus_we_o         = 1'b0;
    bus.mem_resp_valid_o = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_nextState = S_REQ;
        end
      end
      S_REQ: begin
        bus.bus_re_o = ~r_isStore;
        bus.bus_we_o = r_isStore;
        w_nextState  = S_WAIT;
      end
      S_WAIT: begin
        if (w_done) begin
          w_nextState = S_RESP;
        end
      end
      S_RESP: begin
        bus.mem_resp_valid_o = ~r_isStore;
        w_nextState          = S_IDLE;
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_vmu_mem_responder.sv
// Directed bench for vmu_mem_responder: a reactive bus model answers strobes, a monitor logs
// responses and strobes, and one linear sequence checks them against hand-computed values.
module tb_vmu_mem_responder;
  localparam logic [3:0] UOP_LOAD  = 4'd0;
  localparam logic [3:0] UOP_STORE = 4'd1;
  localparam logic [3:0] UOP_OTHER = 4'd7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic err_o;
  logic idle_o;

  int errors = 0;
  int checks = 0;
  int cycleCnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  vmu_mem_responder_if #(.REQ_DATA_WIDTH(32), .ADDR_WIDTH(32), .VECTOR_LANES(8), .MICROOP_WIDTH(4)) vif ();

  vmu_mem_responder #(
    .REQ_DATA_WIDTH(32), .ADDR_WIDTH(32), .VECTOR_LANES(8),
    .FIFO_DEPTH(4), .TIMEOUT(8), .MICROOP_WIDTH(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(vif.slave),
    .err_o(err_o),
    .idle_o(idle_o)
  );

  // Monitor: log every response and strobe together with the cycle it was seen in.
  int          respTicketQ[$];
  logic [31:0] respDataQ[$];
  int          respCycleQ[$];
  int          reCount = 0;
  int          weCount = 0;
  int          lastStrobeCycle = 0;
  logic [31:0] lastReAddr = '0;
  logic [31:0] lastWeAddr = '0;
  logic [31:0] lastWeData = '0;
  logic [3:0]  lastWeBen = '0;

  always @(negedge clk) begin
    if (vif.mem_resp_valid_o) begin
      respTicketQ.push_back(int'(vif.mem_resp_o.ticket));
      respDataQ.push_back(vif.mem_resp_o.data);
      respCycleQ.push_back(cycleCnt);
    end
    if (vif.bus_re_o) begin
      reCount++;
      lastStrobeCycle = cycleCnt;
      lastReAddr = vif.bus_addr_o;
    end
    if (vif.bus_we_o) begin
      weCount++;
      lastStrobeCycle = cycleCnt;
      lastWeAddr = vif.bus_addr_o;
      lastWeData = vif.bus_wdata_o;
      lastWeBen = vif.bus_ben_o;
    end
  end

  // Bus model: completes each strobe busAckDelay cycles later (0 = never), rdata = base ^ addr.
  int          busAckDelay = 1;
  bit          busUseErr = 1'b0;
  bit          busAlsoAck = 1'b0;
  logic [31:0] busRdataBase = '0;
  int          busWait = 0;
  bit          busPending = 1'b0;
  logic [31:0] busAddr = '0;

  always @(negedge clk) begin
    vif.bus_ack_i   = 1'b0;
    vif.bus_err_i   = 1'b0;
    vif.bus_rdata_i = '0;
    if (busPending) begin
      if (busWait <= 1) begin
        busPending      = 1'b0;
        vif.bus_ack_i   = !busUseErr || busAlsoAck;
        vif.bus_err_i   = busUseErr;
        vif.bus_rdata_i = busRdataBase ^ busAddr;
      end else begin
        busWait--;
      end
    end else if ((vif.bus_re_o || vif.bus_we_o) && busAckDelay > 0) begin
      busPending = 1'b1;
      busWait    = busAckDelay;
      busAddr    = vif.bus_addr_o;
    end
  end

  task automatic nextCycle();
    @(negedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [3:0] uop, input int ticket,
                               input logic [31:0] data, output int acceptCycle);
    bit accepted = 1'b0;
    acceptCycle = -1;
    vif.mem_req_valid_i        = 1'b1;
    vif.mem_req_i.address      = addr;
    vif.mem_req_i.microop      = uop;
    vif.mem_req_i.ticket       = 3'(ticket);
    vif.mem_req_i.data         = data;
    for (int i = 0; i < 200 && !accepted; i++) begin
      if (vif.cache_ready_o) begin
        accepted = 1'b1;
        acceptCycle = cycleCnt;
      end
      nextCycle();
    end
    vif.mem_req_valid_i = 1'b0;
    if (!accepted) checkOutput("acceptTimeout", 64'(accepted), 64'd1);
  endtask

  task automatic waitResp(input int target, input string tag);
    for (int i = 0; i < 300 && respDataQ.size() < target; i++) nextCycle();
    checkOutput(tag, 64'(respDataQ.size()), 64'(target));
  endtask

  task automatic applyReset(input string tag);
    rst_n = 1'b0;
    #1;
    checkOutput({tag, "Ready"}, 64'(vif.cache_ready_o), 64'd1);
    checkOutput({tag, "Idle"}, 64'(idle_o), 64'd1);
    checkOutput({tag, "Err"}, 64'(err_o), 64'd0);
    checkOutput({tag, "Strobes"}, 64'({vif.bus_re_o, vif.bus_we_o}), 64'd0);
    checkOutput({tag, "RespValid"}, 64'(vif.mem_resp_valid_o), 64'd0);
    checkOutput({tag, "RespBits"}, 64'(vif.mem_resp_o), 64'd0);
    checkOutput({tag, "Addr"}, 64'(vif.bus_addr_o), 64'd0);
    nextCycle();
    nextCycle();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int acc;
    int base;
    vif.mem_req_valid_i = 1'b0;
    vif.mem_req_i       = '0;
    applyReset("rst");
    nextCycle();

    $display("[TB] single load, exact latency");
    busAckDelay  = 1;
    busRdataBase = 32'hDEADBFEF;
    applyStimulus(32'h100, UOP_LOAD, 3, 32'h0, acc);
    checkOutput("latIdleLow", 64'(idle_o), 64'd0);
    waitResp(1, "latRespCount");
    checkOutput("latReDelay", 64'(lastStrobeCycle - acc), 64'd2);
    checkOutput("latRespDelay", 64'(respCycleQ[0] - acc), 64'd4);
    checkOutput("latReAddr", 64'(lastReAddr), 64'h100);
    checkOutput("latTicket", 64'(respTicketQ[0]), 64'd3);
    checkOutput("latData", 64'(respDataQ[0]), 64'hDEADBEEF);
    nextCycle();
    checkOutput("latIdleBack", 64'(idle_o), 64'd1);

    $display("[TB] load acked two cycles after read strobe");
    busAckDelay = 2;
    applyStimulus(32'h100, UOP_LOAD, 3, 32'h0, acc);
    waitResp(2, "ack2RespCount");
    checkOutput("ack2Delay", 64'(respCycleQ[1] - lastStrobeCycle), 64'd3);
    checkOutput("ack2Ticket", 64'(respTicketQ[1]), 64'd3);
    checkOutput("ack2Data", 64'(respDataQ[1]), 64'hDEADBEEF);

    $display("[TB] single store");
    busAckDelay = 1;
    base = weCount;
    applyStimulus(32'h204, UOP_STORE, 2, 32'h12345678, acc);
    repeat (8) nextCycle();
    checkOutput("stWeCount", 64'(weCount - base), 64'd1);
    checkOutput("stAddr", 64'(lastWeAddr), 64'h204);
    checkOutput("stWdata", 64'(lastWeData), 64'h12345678);
    checkOutput("stBen", 64'(lastWeBen), 64'hF);
    checkOutput("stNoResp", 64'(respDataQ.size()), 64'd2);
    checkOutput("stNoErr", 64'(err_o), 64'd0);

    $display("[TB] fill the queue behind a slow access");
    busAckDelay  = 7;
    busRdataBase = 32'hA5000000;
    base = reCount;
    for (int t = 0; t < 5; t++) applyStimulus(32'h40 + 32'(4 * t), UOP_LOAD, t, 32'h0, acc);
    checkOutput("fullIdle", 64'(idle_o), 64'd0);
    vif.mem_req_valid_i   = 1'b1;
    vif.mem_req_i.address = 32'h80;
    vif.mem_req_i.microop = UOP_LOAD;
    vif.mem_req_i.ticket  = 3'd5;
    for (int i = 0; i < 3; i++) begin
      checkOutput("fullReadyLow", 64'(vif.cache_ready_o), 64'd0);
      nextCycle();
    end
    vif.mem_req_valid_i = 1'b0;
    waitResp(7, "fullRespCount");
    for (int t = 0; t < 5; t++) begin
      checkOutput("fullTicket", 64'(respTicketQ[2 + t]), 64'(t));
      checkOutput("fullData", 64'(respDataQ[2 + t]), 64'(32'hA5000040 + 32'(4 * t)));
    end
    repeat (6) nextCycle();
    checkOutput("fullReCount", 64'(reCount - base), 64'd5);
    checkOutput("fullNoErr", 64'(err_o), 64'd0);

    $display("[TB] load with no ack times out");
    busAckDelay = 0;
    applyStimulus(32'h300, UOP_LOAD, 6, 32'h0, acc);
    waitResp(8, "toRespCount");
    checkOutput("toDelay", 64'(respCycleQ[7] - lastStrobeCycle), 64'd9);
    checkOutput("toTicket", 64'(respTicketQ[7]), 64'd6);
    checkOutput("toData", 64'(respDataQ[7]), 64'd0);
    checkOutput("toErr", 64'(err_o), 64'd1);
    busAckDelay  = 1;
    busRdataBase = 32'hCAFEF109;
    applyStimulus(32'h104, UOP_LOAD, 1, 32'h0, acc);
    waitResp(9, "afterToRespCount");
    checkOutput("afterToTicket", 64'(respTicketQ[8]), 64'd1);
    checkOutput("afterToData", 64'(respDataQ[8]), 64'hCAFEF00D);
    checkOutput("errSticky", 64'(err_o), 64'd1);

    $display("[TB] bus error with simultaneous ack");
    nextCycle();
    applyReset("clr");
    nextCycle();
    busUseErr    = 1'b1;
    busAlsoAck   = 1'b1;
    busRdataBase = 32'h55555555;
    applyStimulus(32'h10, UOP_LOAD, 4, 32'h0, acc);
    waitResp(10, "berrRespCount");
    checkOutput("berrTicket", 64'(respTicketQ[9]), 64'd4);
    checkOutput("berrData", 64'(respDataQ[9]), 64'd0);
    checkOutput("berrErr", 64'(err_o), 64'd1);

    $display("[TB] mixed load/store/load stream");
    busUseErr    = 1'b0;
    busRdataBase = 32'h12340000;
    base = weCount;
    applyStimulus(32'h500, UOP_LOAD, 2, 32'h0, acc);
    applyStimulus(32'h504, UOP_STORE, 3, 32'h11112222, acc);
    applyStimulus(32'h50B, UOP_OTHER, 5, 32'h0, acc);
    waitResp(12, "mixRespCount");
    repeat (10) nextCycle();
    checkOutput("mixOnlyTwo", 64'(respDataQ.size()), 64'd12);
    checkOutput("mixTicketA", 64'(respTicketQ[10]), 64'd2);
    checkOutput("mixDataA", 64'(respDataQ[10]), 64'h12340500);
    checkOutput("mixTicketB", 64'(respTicketQ[11]), 64'd5);
    checkOutput("mixDataB", 64'(respDataQ[11]), 64'h12340508);
    checkOutput("mixWeCount", 64'(weCount - base), 64'd1);
    checkOutput("mixWeAddr", 64'(lastWeAddr), 64'h504);
    checkOutput("mixWeData", 64'(lastWeData), 64'h11112222);

    $display("[TB] reset during an outstanding access");
    busAckDelay = 6;
    base = reCount;
    applyStimulus(32'h600, UOP_LOAD, 7, 32'h0, acc);
    for (int i = 0; i < 20 && reCount == base; i++) nextCycle();
    checkOutput("midReSeen", 64'(reCount - base), 64'd1);
    nextCycle();
    applyReset("mid");
    repeat (10) nextCycle();
    checkOutput("midNoResp", 64'(respDataQ.size()), 64'd12);
    checkOutput("midNoRetry", 64'(reCount - base), 64'd1);
    checkOutput("midIdle", 64'(idle_o), 64'd1);
    checkOutput("midReady", 64'(vif.cache_ready_o), 64'd1);
    checkOutput("midErr", 64'(err_o), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
